stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised successor of the team's 2:1 select mux.
- Merges N valid/ready input streams of W-bit data onto one registered output stream.
- Arbitration is selectable per cycle: round-robin or fixed priority. Optionally holds the grant for a full packet, delimited by `last`.
- Sits between multiple producers (e.g. per-channel front ends) and a single shared consumer.

Parameters:
- N, 4, number of input channels (>=1)
- W, 8, data width per channel
- LOCK_ON_LAST, 1, 1: grant held until the `last` beat of the granted channel is accepted; 0: re-arbitrate after every beat
- SW, max(1,$clog2(N)), derived local parameter, width of `out_sel`

Ports:
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous active-low reset
- in_data  input  N*W  channel i data at bits [i*W +: W]
- in_valid  input  N  per-channel valid
- in_last  input  N  per-channel end-of-packet marker
- in_ready  output  N  per-channel ready (combinational)
- prio_mode  input  1  0 = round-robin, 1 = fixed priority (lowest index wins)
- out_data  output  W  registered output data
- out_valid  output  1  registered output valid
- out_last  output  1  registered output last
- out_sel  output  SW  index of the channel that produced the current output beat
- out_ready  input  1  consumer ready

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_last=0, out_sel=0, rr pointer=0, state=ARB. in_ready=0 while reset_n=0.
- Output register:
  - load_en = !out_valid || out_ready.
  - On load_en with an accepted beat: out_* take the granted channel's data/last/index, out_valid=1.
  - On load_en with no accepted beat: out_valid=0; out_data, out_last and out_sel hold.
  - Latency: 1 cycle from input handshake to out_valid. Full throughput is 1 beat/cycle with out_ready held at 1.
- Handshake:
  - in_ready[i] = load_en && grant[i]. At most one bit of in_ready is set.
  - A beat is accepted on channel i when in_valid[i] && in_ready[i].
  - Inputs must hold data stable while valid && !ready. Outputs obey the same rule.
- Grant (ARB state):
  - Round-robin: first i with in_valid[i]=1, searching from pointer upward with wrap N-1 -> 0.
  - Fixed priority: lowest i with in_valid[i]=1.
  - No valid inputs: no grant.
- State machine (only active when LOCK_ON_LAST=1):
  - ARB -> LOCKED(k): beat accepted from k with in_last[k]=0.
  - LOCKED(k): grant is forced to k regardless of other valids and of prio_mode. If in_valid[k]=0, a bubble results and no other channel is granted.
  - LOCKED(k) -> ARB: beat accepted from k with in_last[k]=1.
  - A single-beat packet (last=1 on the first beat) stays in ARB.
- Pointer update:
  - Set to (k+1) mod N when a beat is accepted from k that ends the grant. That is the last=1 beat, or any beat if LOCK_ON_LAST=0.
  - Updated in both prio_mode settings; it only influences the result in round-robin mode.
- prio_mode changes take effect at the next ARB-state grant computation. They never break an active lock.
- With LOCK_ON_LAST=0, in_last is passed through to out_last but does not affect arbitration.
- Backpressure: with out_valid=1 and out_ready=0, all in_ready=0 and the output holds. State and pointer do not change.
- Reset mid-packet: lock is dropped, pointer returns to 0, and the in-flight output beat is discarded.
- N=1: the channel is always granted when valid; out_sel is held at 0.

Decomposition:
- Package `stream_mux_pkg`:
  - typedef enum logic {ARB, LOCKED} arb_state_e.
  - Function `sel_width(n)` returning max(1,$clog2(n)).
- Sub-module `rr_arbiter`: combinational.
  - Inputs: req[N], pointer[SW], prio_mode.
  - Outputs: one-hot grant[N], grant_idx[SW], any_grant.
- The top holds the lock state, lock index, pointer and output register.

Test Plan:
- Reset: drive reset_n=0 mid-traffic with out_valid=1 -> out_valid=0, out_sel=0 immediately (asynchronous); after release, first grant searches from channel 0.
- Round-robin fairness: N=4, all in_valid=1 with last=1, out_ready=1, prio_mode=0 -> out_sel sequence 0,1,2,3,0,1 on consecutive cycles; out_data matches each channel.
- Fixed priority: prio_mode=1, in_valid=4'b1010 -> out_sel=1 on every cycle; channel 3 starves while channel 1 stays valid.
- Packet lock: ch2 sends a 3-beat packet (last on beat 3) while ch0 is valid -> out_sel=2,2,2, then 0; a mid-packet ch2 valid gap of 2 cycles -> 2-cycle out_valid bubble, ch0 not granted.
- Backpressure: out_ready=0 for 5 cycles with out_valid=1 -> out_data/out_sel stable, all in_ready=0; on out_ready=1, transfer resumes with no beat lost or duplicated (scoreboard by channel).
- LOCK_ON_LAST=0: same stimulus as the packet-lock test -> beats from ch0 and ch2 interleave as 2,0,2,0,2; out_last follows the source beat.

Source files
------------

// File: rtl/stream_mux_pkg.sv
// Shared types and helpers for the N-input valid/ready stream multiplexer.
package stream_mux_pkg;

  typedef enum logic {ARB, LOCKED} arb_state_e;

  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: round-robin from a pointer, or fixed lowest-index priority.
module rr_arbiter #(
  parameter int N  = 4,
  parameter int SW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [SW-1:0] pointer,
  input  logic          prio_mode,
  output logic [N-1:0]  grant,
  output logic [SW-1:0] grant_idx,
  output logic          any_grant
);

  logic [N-1:0] upper_mask;
  logic [N-1:0] req_upper;
  logic [N-1:0] search_vec;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign upper_mask[gi] = (SW'(gi) >= pointer);
    end
  endgenerate

  // Round-robin: prefer requests at or above the pointer, else wrap to the lowest one.
  assign req_upper  = req & upper_mask;
  assign search_vec = (!prio_mode && (|req_upper)) ? req_upper : req;
  assign grant      = search_vec & (~search_vec + N'(1));
  assign any_grant  = |req;

  always_comb begin
    grant_idx = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (search_vec[i]) grant_idx = SW'(i);
    end
  end

endmodule

// File: rtl/stream_mux_rr.sv
// N:1 valid/ready stream merge with selectable round-robin / fixed-priority arbitration,
// optional packet lock on `last`, and a registered output stage.
module stream_mux_rr
  import stream_mux_pkg::*;
#(
  parameter int N            = 4,
  parameter int W            = 8,
  parameter int LOCK_ON_LAST = 1,
  localparam int SW          = sel_width(N)
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [N*W-1:0] in_data,
  input  logic [N-1:0]   in_valid,
  input  logic [N-1:0]   in_last,
  output logic [N-1:0]   in_ready,
  input  logic           prio_mode,
  output logic [W-1:0]   out_data,
  output logic           out_valid,
  output logic           out_last,
  output logic [SW-1:0]  out_sel,
  input  logic           out_ready
);

  arb_state_e    state_reg, state_next;
  logic [SW-1:0] lock_idx_reg, lock_idx_next;
  logic [SW-1:0] ptr_reg, ptr_next;

  logic [N-1:0]  arb_grant;
  logic [SW-1:0] arb_idx;
  logic          arb_any;
  logic [N-1:0]  lock_onehot;
  logic [W-1:0]  chan_data [N];

  logic          locked;
  logic [N-1:0]  grant_vec;
  logic [SW-1:0] grant_idx;
  logic          load_en;
  logic          accept;
  logic          acc_last;
  logic          ends_grant;

  rr_arbiter #(
    .N  (N),
    .SW (SW)
  ) u_arbiter (
    .req       (in_valid),
    .pointer   (ptr_reg),
    .prio_mode (prio_mode),
    .grant     (arb_grant),
    .grant_idx (arb_idx),
    .any_grant (arb_any)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_chan
      assign chan_data[gi]   = in_data[gi*W +: W];
      assign lock_onehot[gi] = (lock_idx_reg == SW'(gi));
    end
  endgenerate

  // A held lock ignores other requesters and prio_mode; an idle locked channel gives a bubble.
  assign locked    = (LOCK_ON_LAST != 0) && (state_reg == LOCKED);
  assign grant_vec = locked ? lock_onehot : (arb_any ? arb_grant : '0);
  assign grant_idx = locked ? lock_idx_reg : arb_idx;

  assign load_en    = !out_valid || out_ready;
  assign in_ready   = (reset_n && load_en) ? grant_vec : '0;
  assign accept     = |(in_valid & in_ready);
  assign acc_last   = in_last[grant_idx];
  assign ends_grant = (LOCK_ON_LAST == 0) || acc_last;

  always_comb begin
    state_next    = state_reg;
    lock_idx_next = lock_idx_reg;
    ptr_next      = ptr_reg;
    if (accept) begin
      if (ends_grant) begin
        state_next = ARB;
        ptr_next   = (grant_idx == SW'(N - 1)) ? '0 : grant_idx + 1'b1;
      end else begin
        state_next    = LOCKED;
        lock_idx_next = grant_idx;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg    <= ARB;
      lock_idx_reg <= '0;
      ptr_reg      <= '0;
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_last     <= 1'b0;
      out_sel      <= '0;
    end else begin
      state_reg    <= state_next;
      lock_idx_reg <= lock_idx_next;
      ptr_reg      <= ptr_next;
      if (load_en) begin
        out_valid <= accept;
        // Payload holds across empty cycles so it only ever changes with a new beat.
        if (accept) begin
          out_data <= chan_data[grant_idx];
          out_last <= acc_last;
          out_sel  <= grant_idx;
        end
      end
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Scoreboard bench for stream_mux_rr: one packet-locking instance and one per-beat instance.
module tb_stream_mux_rr;

  localparam int N  = 4;
  localparam int W  = 8;
  localparam int SW = 2;
  localparam int ND = 2;

  logic           clk = 1'b0;
  logic           reset_n;
  logic [N*W-1:0] in_data   [ND];
  logic [N-1:0]   in_valid  [ND];
  logic [N-1:0]   in_last   [ND];
  logic [N-1:0]   in_ready  [ND];
  logic           prio_mode [ND];
  logic [W-1:0]   out_data  [ND];
  logic           out_valid [ND];
  logic           out_last  [ND];
  logic [SW-1:0]  out_sel   [ND];
  logic           out_ready [ND];

  // Source queues per DUT/channel: {gap[3:0], last, data[7:0]}
  logic [12:0] src_mem  [ND][N][64];
  int          src_head [ND][N];
  int          src_tail [ND][N];
  logic        acc      [ND][N];
  logic        wait_ld  [ND][N];
  int          gap_cnt  [ND][N];
  // Expected output beats: {sel[1:0], last, data[7:0]}
  logic [10:0] exp_mem  [ND][128];
  int          exp_head [ND];
  int          exp_tail [ND];
  int          beat_cnt [ND];

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  stream_mux_rr #(.N(N), .W(W), .LOCK_ON_LAST(1)) dut_lock (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data[0]),
    .in_valid  (in_valid[0]),
    .in_last   (in_last[0]),
    .in_ready  (in_ready[0]),
    .prio_mode (prio_mode[0]),
    .out_data  (out_data[0]),
    .out_valid (out_valid[0]),
    .out_last  (out_last[0]),
    .out_sel   (out_sel[0]),
    .out_ready (out_ready[0])
  );

  stream_mux_rr #(.N(N), .W(W), .LOCK_ON_LAST(0)) dut_beat (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_data   (in_data[1]),
    .in_valid  (in_valid[1]),
    .in_last   (in_last[1]),
    .in_ready  (in_ready[1]),
    .prio_mode (prio_mode[1]),
    .out_data  (out_data[1]),
    .out_valid (out_valid[1]),
    .out_last  (out_last[1]),
    .out_sel   (out_sel[1]),
    .out_ready (out_ready[1])
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dat(input int i, input int j);
    return 8'(i * 64 + j);
  endfunction

  task automatic push_src(input int d, input int i, input int gap, input logic last, input logic [7:0] data);
    src_mem[d][i][src_tail[d][i]] = {4'(gap), last, data};
    src_tail[d][i]++;
  endtask

  task automatic push_exp(input int d, input int sel, input logic last, input logic [7:0] data);
    exp_mem[d][exp_tail[d]] = {2'(sel), last, data};
    exp_tail[d]++;
  endtask

  task automatic wait_drain(input int d);
    logic done;
    logic empty;
    done = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(posedge clk);
      #3;
      empty = (exp_head[d] == exp_tail[d]) && !out_valid[d];
      for (int i = 0; i < N; i++) if (src_head[d][i] != src_tail[d][i]) empty = 1'b0;
      if (empty) begin
        done = 1'b1;
        break;
      end
    end
    check($sformatf("d%0d_drain", d), 32'(done), 32'd1);
  endtask

  // Source driver: pops beats accepted on the previous edge, then presents the next one.
  initial forever begin
    logic [12:0] ent;
    @(posedge clk);
    #1;
    for (int d = 0; d < ND; d++) begin
      for (int i = 0; i < N; i++) begin
        if (acc[d][i] && src_head[d][i] != src_tail[d][i]) begin
          src_head[d][i]++;
          wait_ld[d][i] = 1'b1;
        end
        acc[d][i] = 1'b0;
        if (src_head[d][i] != src_tail[d][i]) begin
          ent = src_mem[d][i][src_head[d][i]];
          if (wait_ld[d][i]) begin
            gap_cnt[d][i] = int'(ent[12:9]);
            wait_ld[d][i] = 1'b0;
          end
          if (gap_cnt[d][i] != 0) begin
            in_valid[d][i] = 1'b0;
            gap_cnt[d][i]--;
          end else begin
            in_valid[d][i]          = 1'b1;
            in_data[d][i*W +: W]    = ent[7:0];
            in_last[d][i]           = ent[8];
          end
        end else begin
          in_valid[d][i] = 1'b0;
        end
      end
    end
  end

  // Monitor: handshakes complete on the following rising edge.
  initial forever begin
    @(negedge clk);
    if (reset_n === 1'b1) begin
      for (int d = 0; d < ND; d++) begin
        check($sformatf("d%0d_ready_onehot", d), 32'($countones(in_ready[d]) <= 1), 32'd1);
        if (out_valid[d] && out_ready[d]) begin
          beat_cnt[d]++;
          $display("[TB] d%0d beat sel=%0d data=%02h last=%0d", d, out_sel[d], out_data[d], out_last[d]);
          if (exp_head[d] == exp_tail[d]) begin
            check($sformatf("d%0d_sb_depth", d), 32'(exp_tail[d] - exp_head[d]), 32'd1);
          end else begin
            check($sformatf("d%0d_beat%0d", d, exp_head[d]),
                  {21'd0, out_sel[d], out_last[d], out_data[d]}, {21'd0, exp_mem[d][exp_head[d]]});
            exp_head[d]++;
          end
        end
        for (int i = 0; i < N; i++) if (in_valid[d][i] && in_ready[d][i]) acc[d][i] = 1'b1;
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] watchdog expired");
    $fatal(1, "simulation timeout");
  end

  initial begin
    int          b0;
    logic        found;
    logic [7:0]  snap_data;
    logic [1:0]  snap_sel;

    reset_n = 1'b1;
    for (int d = 0; d < ND; d++) begin
      in_data[d]   = '0;
      in_valid[d]  = '0;
      in_last[d]   = '0;
      prio_mode[d] = 1'b0;
      out_ready[d] = 1'b1;
      exp_head[d]  = 0;
      exp_tail[d]  = 0;
      beat_cnt[d]  = 0;
      for (int i = 0; i < N; i++) begin
        acc[d][i]      = 1'b0;
        wait_ld[d][i]  = 1'b1;
        gap_cnt[d][i]  = 0;
        src_head[d][i] = 0;
        src_tail[d][i] = 0;
      end
    end
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check("rst_out_valid", 32'(out_valid[0]), 32'd0);
    check("rst_out_sel",   32'(out_sel[0]),   32'd0);
    check("rst_out_data",  32'(out_data[0]),  32'd0);
    check("rst_out_last",  32'(out_last[0]),  32'd0);
    check("rst_beat_valid", 32'(out_valid[1]), 32'd0);
    @(posedge clk);
    #3 reset_n = 1'b1;

    // Round-robin rotation with single-beat packets, full throughput.
    @(posedge clk);
    #3;
    b0 = beat_cnt[0];
    for (int j = 0; j < 2; j++) begin
      for (int i = 0; i < N; i++) begin
        push_src(0, i, 0, 1'b1, dat(i, j));
        push_exp(0, i, 1'b1, dat(i, j));
      end
    end
    repeat (10) @(posedge clk);
    #3;
    check("rr_throughput", 32'(beat_cnt[0] - b0), 32'd8);
    wait_drain(0);

    // Fixed priority: channel 3 waits until channel 1 runs dry.
    prio_mode[0] = 1'b1;
    for (int j = 0; j < 4; j++) begin
      push_src(0, 1, 0, 1'b1, dat(1, 4 + j));
      push_src(0, 3, 0, 1'b1, dat(3, 4 + j));
    end
    for (int j = 0; j < 4; j++) push_exp(0, 1, 1'b1, dat(1, 4 + j));
    for (int j = 0; j < 4; j++) push_exp(0, 3, 1'b1, dat(3, 4 + j));
    wait_drain(0);
    prio_mode[0] = 1'b0;

    // Packet lock with a 2-cycle gap in ch2, applied to both instances.
    for (int d = 0; d < ND; d++) begin
      push_src(d, 2, 0, 1'b0, dat(2, 8));
      push_src(d, 2, 0, 1'b0, dat(2, 9));
      push_src(d, 2, 2, 1'b1, dat(2, 10));
      push_src(d, 0, 1, 1'b0, dat(0, 8));
      push_src(d, 0, 0, 1'b1, dat(0, 9));
    end
    push_exp(0, 2, 1'b0, dat(2, 8));
    push_exp(0, 2, 1'b0, dat(2, 9));
    push_exp(0, 2, 1'b1, dat(2, 10));
    push_exp(0, 0, 1'b0, dat(0, 8));
    push_exp(0, 0, 1'b1, dat(0, 9));
    push_exp(1, 2, 1'b0, dat(2, 8));
    push_exp(1, 0, 1'b0, dat(0, 8));
    push_exp(1, 2, 1'b0, dat(2, 9));
    push_exp(1, 0, 1'b1, dat(0, 9));
    push_exp(1, 2, 1'b1, dat(2, 10));
    wait_drain(0);
    wait_drain(1);

    // Backpressure: pointer now sits at 1 after the ch0 packet.
    for (int j = 0; j < 3; j++) begin
      for (int i = 0; i < N; i++) push_src(0, i, 0, 1'b1, dat(i, 16 + j));
      for (int k = 1; k <= N; k++) push_exp(0, k % N, 1'b1, dat(k % N, 16 + j));
    end
    repeat (4) @(posedge clk);
    #3 out_ready[0] = 1'b0;
    @(negedge clk);
    snap_data = out_data[0];
    snap_sel  = out_sel[0];
    check("bp_valid", 32'(out_valid[0]), 32'd1);
    check("bp_in_ready", 32'(in_ready[0]), 32'd0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp_data_c%0d", c), 32'(out_data[0]), 32'(snap_data));
      check($sformatf("bp_sel_c%0d", c), 32'(out_sel[0]), 32'(snap_sel));
      check($sformatf("bp_ready_c%0d", c), 32'(in_ready[0]), 32'd0);
    end
    @(posedge clk);
    #3 out_ready[0] = 1'b1;
    wait_drain(0);

    // Reset in the middle of a locked ch2 packet.
    for (int j = 0; j < 4; j++) begin
      push_src(0, 2, 0, (j == 3), dat(2, 20 + j));
      push_exp(0, 2, (j == 3), dat(2, 20 + j));
    end
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #3;
      if (out_valid[0] && out_sel[0] == 2'd2) begin
        found = 1'b1;
        break;
      end
    end
    check("rst_mid_found", 32'(found), 32'd1);
    reset_n = 1'b0;
    #1;
    check("rst_async_valid", 32'(out_valid[0]), 32'd0);
    check("rst_async_sel", 32'(out_sel[0]), 32'd0);
    check("rst_async_in_ready", 32'(in_ready[0]), 32'd0);
    for (int i = 0; i < N; i++) begin
      src_head[0][i] = src_tail[0][i];
      acc[0][i]      = 1'b0;
      wait_ld[0][i]  = 1'b1;
      gap_cnt[0][i]  = 0;
    end
    exp_head[0] = exp_tail[0];
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    push_src(0, 0, 0, 1'b1, dat(0, 30));
    push_src(0, 1, 0, 1'b1, dat(1, 30));
    push_exp(0, 0, 1'b1, dat(0, 30));
    push_exp(0, 1, 1'b1, dat(1, 30));
    wait_drain(0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
